// File: rtl/obi_mem_if.sv
// OBI request/response bundle between a CPU-side requester and a memory responder.
interface obi_mem_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              proc_req_in;
  logic [ADDR_W-1:0] addr_in;
  logic              web_in;
  logic [DATA_W-1:0] wdata_in;
  logic              rdy_out;
  logic [DATA_W-1:0] rdata_out;
  logic              valid_out;

  modport master (
    output proc_req_in, addr_in, web_in, wdata_in,
    input  rdy_out, rdata_out, valid_out
  );

  modport slave (
    input  proc_req_in, addr_in, web_in, wdata_in,
    output rdy_out, rdata_out, valid_out
  );
endinterface

// File: rtl/obi_mem_slave.sv
// Word-addressed OBI memory responder with fixed-latency, in-order responses.
// Optional OBI_MEM_STALL_EN adds LFSR-driven pseudo-random grant stalls.
module obi_mem_slave #(
  parameter int DATA_W          = 32,
  parameter int ADDR_W          = 32,
  parameter int DEPTH_WORDS     = 1024,
  parameter int LATENCY         = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input logic      clk,
  input logic      rst,
  obi_mem_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [DATA_W-1:0]  mem [DEPTH_WORDS];
  logic [IDX_W-1:0]   idx;
  logic [LATENCY-1:0] vld_p;
  logic [DATA_W-1:0]  dat_p [LATENCY];
  logic [CNT_W-1:0]   count;
  logic               stall;
  logic               accept;
  logic               valid;
  logic               unused_addr;

  assign idx         = bus.addr_in[IDX_W+1:2];
  assign unused_addr = ^{bus.addr_in[ADDR_W-1:IDX_W+2], bus.addr_in[1:0]};

`ifdef OBI_MEM_STALL_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk) begin
    if (rst) lfsr <= 8'hA5;
    else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  assign valid         = vld_p[LATENCY-1];
  // A retiring response frees its slot in the same cycle, so grant stays up.
  assign bus.rdy_out   = !rst && !stall &&
                         ((count < CNT_W'(MAX_OUTSTANDING)) || valid);
  assign accept        = bus.proc_req_in && bus.rdy_out;
  assign bus.valid_out = valid;
  assign bus.rdata_out = valid ? dat_p[LATENCY-1] : '0;

  // Accept edge: storage write, or read sampled into stage 0
  always_ff @(posedge clk) begin
    if (accept && !bus.web_in) mem[idx] <= bus.wdata_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= accept;
      for (int i = 1; i < LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // Stages 1..LATENCY-1: data shifts freely, qualified only by vld_p
  always_ff @(posedge clk) begin
    dat_p[0] <= (accept && bus.web_in) ? mem[idx] : '0;
    for (int i = 1; i < LATENCY; i++) dat_p[i] <= dat_p[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      case ({accept, valid})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_obi_mem_slave.sv
// Bench for obi_mem_slave: two instances (LATENCY 2/MAX 2 and LATENCY 3/MAX 1) against a cycle-level model.
module tb_obi_mem_slave;
  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  obi_mem_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
  obi_mem_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

  obi_mem_slave #(.DATA_W(DW), .ADDR_W(AW), .DEPTH_WORDS(DEPTH),
                  .LATENCY(2), .MAX_OUTSTANDING(2))
    dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));

  obi_mem_slave #(.DATA_W(DW), .ADDR_W(AW), .DEPTH_WORDS(DEPTH),
                  .LATENCY(3), .MAX_OUTSTANDING(1))
    dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  int          lat [2] = '{2, 3};
  int          mo  [2] = '{2, 1};
  logic [31:0] mmem   [2][DEPTH];
  bit          mknown [2][DEPTH];
  bit          svld   [2][16];
  bit          sknown [2][16];
  logic [31:0] sdat   [2][16];
  logic [7:0]  mlfsr  [2] = '{8'hA5, 8'hA5};
  int          t;
  int          act;
  int          checks;
  int          passed;

  task automatic drive(input int d, input bit req, input bit web,
                       input logic [31:0] a, input logic [31:0] w);
    if (d == 0) begin
      bus0.proc_req_in = req; bus0.web_in = web; bus0.addr_in = a; bus0.wdata_in = w;
    end else begin
      bus1.proc_req_in = req; bus1.web_in = web; bus1.addr_in = a; bus1.wdata_in = w;
    end
  endtask

  task automatic get_in(input int d, output bit req, output bit web,
                        output logic [31:0] a, output logic [31:0] w);
    if (d == 0) begin
      req = bus0.proc_req_in; web = bus0.web_in; a = bus0.addr_in; w = bus0.wdata_in;
    end else begin
      req = bus1.proc_req_in; web = bus1.web_in; a = bus1.addr_in; w = bus1.wdata_in;
    end
  endtask

  // Outstanding = accepts whose response cycle lies in [t, t+LATENCY).
  function automatic bit model_rdy(input int d);
    int cnt = 0;
    for (int k = 0; k < lat[d]; k++) if (svld[d][(t + k) % 16]) cnt++;
    model_rdy = (rst === 1'b0) && (cnt < mo[d] || svld[d][t % 16]);
`ifdef OBI_MEM_STALL_EN
    if (mlfsr[d][1:0] == 2'b00) model_rdy = 1'b0;
`endif
  endfunction

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      bit r, req, web;
      logic [31:0] a, w;
      int idx, slot;
      r = model_rdy(d);
      get_in(d, req, web, a, w);
      idx  = int'((a >> 2) % DEPTH);
      slot = (t + lat[d]) % 16;
      svld[d][t % 16] = 1'b0;
      if (rst) begin
        for (int k = 0; k < 16; k++) svld[d][k] = 1'b0;
        mlfsr[d] = 8'hA5;
      end else begin
        if (req && r) begin
          if (!web) begin
            mmem[d][idx] = w; mknown[d][idx] = 1'b1;
            sdat[d][slot] = 32'h0; sknown[d][slot] = 1'b1;
          end else begin
            sdat[d][slot] = mmem[d][idx]; sknown[d][slot] = mknown[d][idx];
          end
          svld[d][slot] = 1'b1;
        end
        mlfsr[d] = {mlfsr[d][6:0], mlfsr[d][7] ^ mlfsr[d][5] ^ mlfsr[d][4] ^ mlfsr[d][3]};
      end
    end
    t++;
  endtask

  // One cycle: compare active instance outputs, then advance across the edge.
  task automatic step(input string tag, output bit acc, output logic gr, output logic gv);
    bit r, v, req, web;
    logic [31:0] a, w, ed, gd;
    #1;
    r = model_rdy(act);
    v = svld[act][t % 16];
    gr = (act == 0) ? bus0.rdy_out   : bus1.rdy_out;
    gv = (act == 0) ? bus0.valid_out : bus1.valid_out;
    gd = (act == 0) ? bus0.rdata_out : bus1.rdata_out;
    checks++;
    if (gr !== r) $display("FAIL %s rdy_out cycle %0d: got %b expected %b", tag, t, gr, r);
    else passed++;
    checks++;
    if (gv !== v) $display("FAIL %s valid_out cycle %0d: got %b expected %b", tag, t, gv, v);
    else passed++;
    if (!v || sknown[act][t % 16]) begin
      ed = v ? sdat[act][t % 16] : 32'h0;
      checks++;
      if (gd !== ed) $display("FAIL %s rdata_out cycle %0d: got %h expected %h", tag, t, gd, ed);
      else passed++;
    end
    get_in(act, req, web, a, w);
    acc = req && r;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle(input int n, input string tag);
    bit acc; logic gr, gv;
    drive(act, 1'b0, 1'b1, 32'h0, 32'h0);
    for (int i = 0; i < n; i++) step(tag, acc, gr, gv);
  endtask

  task automatic issue(input int d, input bit web, input logic [31:0] a,
                       input logic [31:0] w, input string tag);
    bit acc = 1'b0; logic gr, gv; int n = 0;
    act = d;
    drive(d, 1'b1, web, a, w);
    while (!acc && n < 50) begin step(tag, acc, gr, gv); n++; end
    drive(d, 1'b0, 1'b1, 32'h0, 32'h0);
    if (!acc) begin
      checks++;
      $display("FAIL %s grant: none within 50 cycles, required a grant", tag);
    end
  endtask

  task automatic test_reset();
    bit acc; logic gr, gv;
    act = 0;
    rst = 1'b1;
    drive(0, 1'b1, 1'b1, 32'h10, 32'h0);
    for (int i = 0; i < 3; i++) step("reset", acc, gr, gv);
    rst = 1'b0;
    idle(2, "reset_release");
  endtask

  task automatic test_write_read();
    issue(0, 1'b0, 32'h10, 32'hDEADBEEF, "wr_deadbeef");
    issue(0, 1'b1, 32'h10, 32'h0, "rd_deadbeef");
    idle(4, "wr_rd_drain");
  endtask

  task automatic test_back_to_back();
    issue(0, 1'b0, 32'h0, 32'h11, "preload0");
    issue(0, 1'b0, 32'h4, 32'h22, "preload1");
    issue(0, 1'b0, 32'h8, 32'h33, "preload2");
    idle(3, "preload_drain");
    issue(0, 1'b1, 32'h0, 32'h0, "b2b_rd0");
    issue(0, 1'b1, 32'h4, 32'h0, "b2b_rd1");
    issue(0, 1'b1, 32'h8, 32'h0, "b2b_rd2");
    idle(4, "b2b_drain");
  endtask

  task automatic test_lat3();
    bit acc; logic gr, gv; int nr = 0;
    issue(1, 1'b0, 32'h0, 32'h12345678, "lat3_wr");
    idle(5, "lat3_settle");
    drive(1, 1'b1, 1'b1, 32'h0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      step("lat3_cont", acc, gr, gv);
      if (gr === 1'b1) nr++;
    end
`ifndef OBI_MEM_STALL_EN
    checks++;
    if (nr !== 4) $display("FAIL lat3_grants: got %0d grant cycles, required 4", nr);
    else passed++;
`endif
    idle(5, "lat3_drain");
  endtask

  task automatic test_reset_midflight();
    bit acc; logic gr, gv;
    issue(0, 1'b0, 32'h20, 32'h5A5A5A5A, "mid_wr");
    issue(0, 1'b1, 32'h20, 32'h0, "mid_rd");
    rst = 1'b1;
    step("mid_rst", acc, gr, gv);
    rst = 1'b0;
    idle(4, "mid_after");
    issue(0, 1'b1, 32'h20, 32'h0, "mid_reread");
    idle(4, "mid_drain");
  endtask

  task automatic test_wrap();
    issue(0, 1'b0, 32'h1000, 32'hCAFEF00D, "wrap_wr");
    issue(0, 1'b1, 32'h0000, 32'h0, "wrap_rd0");
    issue(0, 1'b1, 32'h1003, 32'h0, "wrap_rd1003");
    idle(4, "wrap_drain");
  endtask

  task automatic test_continuous(input int d);
    bit acc; logic gr, gv; int nr = 0, nv = 0;
    act = d;
    rst = 1'b1;
    drive(d, 1'b0, 1'b1, 32'h0, 32'h0);
    step("cont_rst", acc, gr, gv);
    rst = 1'b0;
    drive(d, 1'b1, 1'b1, 32'h0, 32'h0);
    for (int i = 0; i < 40; i++) begin
      step("cont_req", acc, gr, gv);
      if (gr === 1'b1) nr++;
      if (gv === 1'b1) nv++;
    end
    drive(d, 1'b0, 1'b1, 32'h0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      step("cont_drain", acc, gr, gv);
      if (gv === 1'b1) nv++;
    end
    checks++;
    if (nv !== nr) $display("FAIL cont_count dut%0d: got %0d responses, required %0d", d, nv, nr);
    else passed++;
  endtask

  task automatic test_random();
    bit acc = 1'b1, req, web; logic gr, gv; logic [31:0] a, w;
    act = 0;
    for (int i = 0; i < 300; i++) begin
      if (acc || !req) begin
        req = ($urandom % 4) != 0;
        web = $urandom % 2;
        a   = ($urandom_range(0, 15) << 2) | ($urandom % 4) | (($urandom % 4) << 12);
        w   = $urandom;
        drive(0, req, web, a, w);
      end
      step("random", acc, gr, gv);
    end
    idle(4, "random_drain");
  endtask

  initial begin
    rst = 1'b1;
    t = 0; act = 0; checks = 0; passed = 0;
    drive(0, 1'b0, 1'b1, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b1, 32'h0, 32'h0);
    @(negedge clk);
    test_reset();
    test_write_read();
    test_back_to_back();
    test_lat3();
    test_reset_midflight();
    test_wrap();
    test_continuous(0);
    test_continuous(1);
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/obi_mem_slave.md
Name: obi_mem_slave

Overview:
Memory-side OBI responder sitting directly downstream of the CPU's OBI interface; one instance serves the IRAM port, another the DRAM port.
- Accepts req/addr/web/wdata and grants via rdy.
- Holds a word-addressed storage array.
- Returns rdata with valid after a fixed, parameterised latency, in order, with a bounded number of outstanding transactions.
- Serves as the synthesizable/simulation memory for the Fetcher and LoadStoreUnit paths.

Parameters:
- DATA_W, 32, data word width.
- ADDR_W, 32, byte address width.
- DEPTH_WORDS, 1024, storage words; power of two.
- LATENCY, 2, cycles from accept edge to valid_out; legal range is at least 1.
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered transactions; legal range is at least 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- proc_req_in  in  1  request from the OBI interface.
- addr_in  in  ADDR_W  byte address.
- web_in  in  1  write enable, active low: 0 is write, 1 is read.
- wdata_in  in  DATA_W  write data.
- rdy_out  out  1  grant; the transaction is accepted when proc_req_in and rdy_out are both high at a rising edge.
- rdata_out  out  DATA_W  response data.
- valid_out  out  1  response valid, one-cycle pulse per accepted transaction.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values:
  - valid_out=0, rdata_out=0.
  - Response pipeline and outstanding count are cleared.
  - rdy_out=0 while rst is high.
  - Storage contents are NOT reset.
- Indexing:
  - Word index = addr_in[log2(DEPTH_WORDS)+1:2].
  - addr bits [1:0] are ignored.
  - Upper bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- Grant:
  - rdy_out = !rst && (count < MAX_OUTSTANDING || valid_out), combinational.
  - With the optional stall feature, rdy_out is additionally gated (see Optional Feature).
- Accept:
  - Write (web_in=0): the storage word is written at the accept edge.
  - Read (web_in=1): the storage word is sampled at the accept edge.
  - Reads therefore observe every write accepted earlier, including the write accepted on the immediately preceding edge.
- Response pipeline:
  - LATENCY-deep shift register of {valid, data}, shifted every cycle and never stalled.
  - valid_out rises exactly LATENCY cycles after the accept edge, high for one cycle.
  - Responses are returned strictly in acceptance order.
  - A write response carries rdata_out=0.
  - When valid_out=0, rdata_out is held at 0.
- Outstanding count (width clog2(MAX_OUTSTANDING+1)):
  - Increments on accept.
  - Decrements on a cycle with valid_out=1.
  - Accept and retire in the same cycle leave count unchanged.
  - count never exceeds MAX_OUTSTANDING.
  - If MAX_OUTSTANDING >= LATENCY, the grant never deasserts due to count.
- Request while rdy_out=0: not accepted; no state change.
  - Requester holds addr/web/wdata, per OBI.
- Reset mid-operation:
  - In-flight responses are discarded; no valid_out for them.
  - Writes already accepted persist.
- Simultaneous reset and request: reset wins; nothing is accepted.

Optional Feature:
- Macro: OBI_MEM_STALL_EN.
- Defined:
  - 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1.
  - Loaded with 8'hA5 on rst and advanced every non-reset cycle.
  - rdy_out is forced low whenever lfsr[1:0]==2'b00, regardless of count.
  - Response timing of already-accepted transactions is unaffected.
  - Used to exercise Fetcher/LSU wait handling.
- Not defined: no LFSR is present; rdy_out depends only on rst, count and valid_out.

Test Plan:
- Default params, macro off:
  - Write 32'hDEADBEEF to 0x10 (web_in=0), then read 0x10 on the next cycle.
  - Required: valid_out pulses 2 cycles after each accept.
  - Write response rdata_out=0; read response rdata_out=32'hDEADBEEF.
- Default params:
  - Preload words 0,1,2 with 0x11, 0x22, 0x33.
  - Issue reads 0x0, 0x4, 0x8 with proc_req_in held high for 3 consecutive cycles.
  - Required: rdy_out stays 1; valid_out is high 3 consecutive cycles with data 0x11, 0x22, 0x33 in order.
- LATENCY=3, MAX_OUTSTANDING=1, continuous reads:
  - Required: accepts on cycles 0, 3, 6; rdy_out=0 on cycles 1-2 and 4-5.
  - valid_out high on cycles 3, 6, 9.
- Reset mid-flight:
  - Write 0x5A5A5A5A to 0x20, read 0x20 at cycle n, assert rst at cycle n+1 for 1 cycle.
  - Required: no valid_out for that read.
  - A subsequent read of 0x20 returns 0x5A5A5A5A.
- Wrap-around, DEPTH_WORDS=1024:
  - Write 0xCAFEF00D to 0x1000, then read 0x0000.
  - Required: read returns 0xCAFEF00D. Read of 0x1003 also returns it.
- OBI_MEM_STALL_EN defined, continuous requests after reset:
  - Required: rdy_out=0 exactly on cycles where the reference LFSR model (seed 8'hA5) has [1:0]==0.
  - Accepted count equals the number of rdy_out=1 cycles.
  - Responses remain in order at LATENCY.
